// File: rtl/dtree_pkg.sv
// dtree_pkg: shared types, constants and node table
// for the decision-tree sequencer.
package dtree_pkg;

    localparam int N_FEAT = 16;
    localparam int FEAT_W = 8;
    localparam int CLASS_W = 4;
    localparam logic [CLASS_W-1:0] ERR_CLASS = 4'hF;
    localparam int IDX_W = 8;
    localparam int TBL_N = 64;

    typedef struct packed {
        logic               is_leaf;
        logic [3:0]         fidx;
        logic [FEAT_W-1:0]  thr;
        logic [IDX_W-1:0]   left;
        logic [IDX_W-1:0]   right;
        logic [CLASS_W-1:0] cls;
    } node_t;

    typedef node_t [TBL_N-1:0] node_tbl_t;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic node_t mk_node(
        input logic [3:0]        fidx,
        input logic [FEAT_W-1:0] thr,
        input logic [IDX_W-1:0]  l,
        input logic [IDX_W-1:0]  r
    );
        node_t n;
        n = '0;
        n.fidx = fidx;
        n.thr = thr;
        n.left = l;
        n.right = r;
        return n;
    endfunction

    function automatic node_t mk_leaf(input logic [CLASS_W-1:0] c);
        node_t n;
        n = '0;
        n.is_leaf = 1'b1;
        n.cls = c;
        return n;
    endfunction

    function automatic node_tbl_t mk_table();
        node_tbl_t t;
        for (int i = 0; i < TBL_N; i++) begin
            t[i] = mk_leaf('0);
        end
        t[0] = mk_node(4'd7, 8'h0F, 8'd1, 8'd2);
        t[1] = mk_leaf(4'd3);
        t[2] = mk_node(4'd15, 8'h7F, 8'd3, 8'd4);
        t[3] = mk_leaf(4'd5);
        t[4] = mk_leaf(4'd9);
        return t;
    endfunction

    localparam node_tbl_t NODE_TABLE = mk_table();

    // Constant-index mux keeps the lookup free of index-width games.
    function automatic node_t tbl_get(input node_tbl_t t, input int idx);
        node_t r;
        r = mk_leaf(ERR_CLASS);
        for (int i = 0; i < TBL_N; i++) begin
            if (i == idx) r = t[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/dtree_node_eval.sv
// dtree_node_eval: one shared unsigned comparator
// picking the child of the current node.
module dtree_node_eval
    import dtree_pkg::*;
(
    input  node_t                          nd,
    input  logic [N_FEAT-1:0][FEAT_W-1:0]  feat,
    output logic [IDX_W-1:0]               nxt,
    output logic                           leaf,
    output logic [CLASS_W-1:0]             cls
);

    // Inclusive compare: equality goes left.
    always_comb begin
        leaf = nd.is_leaf;
        cls = nd.cls;
        nxt = (feat[nd.fidx] <= nd.thr) ? nd.left : nd.right;
    end

endmodule

// File: rtl/dtree_seq_ctrl.sv
// dtree_seq_ctrl: loads 16 feature beats, walks the
// node table one node per cycle, returns a class.
module dtree_seq_ctrl
    import dtree_pkg::*;
#(
    parameter int        N_NODES  = 64,
    parameter int        MAX_WALK = 32,
    parameter node_tbl_t TABLE    = NODE_TABLE
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [FEAT_W-1:0]   in_feat,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [CLASS_W-1:0]  out_class,
    output logic                out_err,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int NODE_W = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int LIM = (N_NODES < TBL_N) ? N_NODES : TBL_N;
    localparam int WC_W = $clog2(MAX_WALK + 1);

    state_t                         state;
    state_t                         state_n;
    logic [3:0]                     beat_cnt;
    logic [WC_W-1:0]                walk_cnt;
    logic [NODE_W-1:0]              node;
    logic [N_FEAT-1:0][FEAT_W-1:0]  feat;
    node_t                          cur;
    logic [IDX_W-1:0]               nxt;
    logic                           ev_leaf;
    logic [CLASS_W-1:0]             ev_cls;
    logic [CLASS_W-1:0]             cls_n;
    logic                           err_n;
    logic                           xfer;

    assign in_ready = (state == LOAD);
    assign out_valid = (state == DONE);
    assign xfer = in_valid && in_ready;
    assign cur = tbl_get(TABLE, int'(node));

    dtree_node_eval u_eval (
        .nd   (cur),
        .feat (feat),
        .nxt  (nxt),
        .leaf (ev_leaf),
        .cls  (ev_cls)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    // Next state and result selection.
    always_comb begin
        state_n = state;
        cls_n = out_class;
        err_n = out_err;
        unique case (state)
            LOAD: begin
                if (xfer && beat_cnt == 4'hF) state_n = WALK;
            end
            WALK: begin
                if (ev_leaf) begin
                    cls_n = ev_cls;
                    err_n = 1'b0;
                    state_n = DONE;
                end else if (int'(nxt) >= LIM ||
                             walk_cnt == WC_W'(MAX_WALK - 1)) begin
                    cls_n = ERR_CLASS;
                    err_n = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_n = LOAD;
            end
            default: state_n = LOAD;
        endcase
    end

    // Feature file; deliberately not reset.
    always_ff @(posedge clk) begin
        if (xfer && !rst) feat[beat_cnt] <= in_feat;
    end

    // Counters, node pointer and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            walk_cnt <= '0;
            node <= '0;
            out_class <= '0;
            out_err <= 1'b0;
        end else begin
            if (xfer) beat_cnt <= beat_cnt + 4'd1;
            if (state == WALK) begin
                walk_cnt <= walk_cnt + WC_W'(1);
                node <= NODE_W'(nxt);
            end else begin
                walk_cnt <= '0;
                node <= '0;
            end
            out_class <= cls_n;
            out_err <= err_n;
        end
    end

endmodule

// File: tb/tb_dtree_seq_ctrl.sv
// tb_dtree_seq_ctrl: directed scoreboard bench for
// the decision-tree sequencer.
module tb_dtree_seq_ctrl;
    import dtree_pkg::*;

    localparam int MW = 32;

    typedef struct {
        logic [3:0] cls;
        logic       err;
        int         lat;
    } exp_t;

    function automatic node_tbl_t loop_tbl();
        node_tbl_t t;
        t = NODE_TABLE;
        t[0].left = '0;
        t[0].right = '0;
        return t;
    endfunction

    localparam node_tbl_t LOOP_TBL = loop_tbl();

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_feat = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_class;
    logic       out_err;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] l_feat = '0;
    logic       l_valid = 1'b0;
    logic       l_iready;
    logic [3:0] l_class;
    logic       l_err;
    logic       l_ovalid;
    logic       l_oready = 1'b1;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    dtree_seq_ctrl #(.N_NODES(64), .MAX_WALK(MW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_feat   (in_feat),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_class (out_class),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    dtree_seq_ctrl #(.N_NODES(64), .MAX_WALK(MW), .TABLE(LOOP_TBL)) u_loop (
        .clk       (clk),
        .rst       (rst),
        .in_feat   (l_feat),
        .in_valid  (l_valid),
        .in_ready  (l_iready),
        .out_class (l_class),
        .out_err   (l_err),
        .out_valid (l_ovalid),
        .out_ready (l_oready)
    );

    function automatic exp_t model(input logic [15:0][7:0] f);
        exp_t e;
        if (f[7] <= 8'h0F)       e = '{4'd3, 1'b0, 3};
        else if (f[15] <= 8'h7F) e = '{4'd5, 1'b0, 4};
        else                     e = '{4'd9, 1'b0, 4};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [15:0][7:0] f,
                        input bit push);
        for (int i = 0; i < 16; i++) begin
            if (sel) begin
                l_feat = f[i];
                l_valid = 1'b1;
            end else begin
                in_feat = f[i];
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        l_valid = 1'b0;
        in_valid = 1'b0;
        if (push) begin
            if (sel) q.push_back('{ERR_CLASS, 1'b1, MW + 1});
            else     q.push_back(model(f));
        end
    endtask

    task automatic collect(input bit sel, input string tag);
        int   n;
        logic seen;
        logic rdy;
        exp_t e;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = sel ? l_ovalid : out_valid;
        end
        chk({tag, ".valid"}, 32'(seen), 32'd1);
        chk({tag, ".sb_depth"}, 32'(q.size()), 32'd1);
        if (q.size() == 0) return;
        e = q.pop_front();
        chk({tag, ".lat"}, 32'(n), 32'(e.lat));
        chk({tag, ".class"}, 32'(sel ? l_class : out_class), 32'(e.cls));
        chk({tag, ".err"}, 32'(sel ? l_err : out_err), 32'(e.err));
        rdy = sel ? l_oready : out_ready;
        if (rdy) begin
            @(posedge clk);
            #1;
            chk({tag, ".drop"}, 32'(sel ? l_ovalid : out_valid), 32'd0);
            chk({tag, ".iready"}, 32'(sel ? l_iready : in_ready), 32'd1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0][7:0] f;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.ovalid", 32'(out_valid), 32'd0);
        chk("rst.class", 32'(out_class), 32'd0);
        chk("rst.err", 32'(out_err), 32'd0);
        chk("rst.iready", 32'(in_ready), 32'd1);
        chk("rst.l_ovalid", 32'(l_ovalid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        f = '0;
        send(0, f, 1);
        collect(0, "zeros");

        f = {16{8'hFF}};
        f[7] = 8'h0F;
        send(0, f, 1);
        collect(0, "thr_eq");

        f = {16{8'h33}};
        f[7] = 8'h10;
        f[15] = 8'h7F;
        send(0, f, 1);
        collect(0, "right_eq");

        f[15] = 8'h80;
        send(0, f, 1);
        collect(0, "right_gt");

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) f[i] = 8'($urandom);
            f[7] = 8'($urandom_range(0, 31));
            send(0, f, 1);
            collect(0, "rand");
        end

        out_ready = 1'b0;
        f = '0;
        f[7] = 8'h20;
        f[15] = 8'h01;
        send(0, f, 1);
        collect(0, "bp");
        repeat (6) begin
            in_feat = 8'hAA;
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.hold_class", 32'(out_class), 32'd5);
            chk("bp.hold_err", 32'(out_err), 32'd0);
            chk("bp.iready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp.drop", 32'(out_valid), 32'd0);
        chk("bp.reload", 32'(in_ready), 32'd1);

        f = {16{8'hFF}};
        f[0] = 8'h00;
        f[7] = 8'h05;
        send(0, f, 1);
        collect(0, "after_bp");

        for (int i = 0; i < 8; i++) begin
            in_feat = 8'hFF;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_load.rst_ovalid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_load.iready", 32'(in_ready), 32'd1);
        f = '0;
        f[7] = 8'h0A;
        send(0, f, 1);
        collect(0, "fresh");

        for (int i = 0; i < 16; i++) f[i] = 8'($urandom);
        send(1, f, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_walk.rst_ovalid", 32'(l_ovalid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_walk.iready", 32'(l_iready), 32'd1);

        send(1, f, 1);
        collect(1, "loop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dtree_seq_ctrl.md
DTREE_SEQ_CTRL -- requirements
Module: dtree_seq_ctrl

Interface
REQ-001 Parameter N_NODES, default 64, SHALL give the node-table depth (node index width NODE_W = clog2(N_NODES)).
REQ-002 Parameter MAX_WALK, default 32, SHALL give the walk-cycle limit before abort.
REQ-003 clk  input  1 -- single clock, rising edge.
REQ-004 rst  input  1 -- synchronous, active-high reset.
REQ-005 in_feat  input  8 -- one unsigned feature value per beat, feature 0 first.
REQ-006 in_valid  input  1 / in_ready  output  1 -- feature beat handshake; a beat transfers when both are high.
REQ-007 out_class  output  4 -- predicted class.
REQ-008 out_err  output  1 -- walk aborted on MAX_WALK.
REQ-009 out_valid  output  1 / out_ready  input  1 -- result handshake; a result transfers when both are high.

Function
REQ-010 The block SHALL hold a 16 x 8-bit feature register file and evaluate one shared unsigned comparator per cycle against a constant node table.
REQ-011 The FSM SHALL have states LOAD, WALK and DONE, and SHALL be in LOAD after reset.
REQ-012 LOAD: in_ready=1; each accepted beat SHALL write feat[beat_cnt] and increment the 4-bit beat_cnt; the beat with beat_cnt=15 SHALL move the FSM to WALK with node=0, walk_cnt=0 and beat_cnt wrapping to 0.
REQ-013 WALK: in_ready=0; per cycle the node entry SHALL be read.
- Internal node: next node = left if feat[fidx] <= thr, else right.
- Leaf: out_class SHALL be loaded with the leaf class, out_err cleared, FSM to DONE.
REQ-014 WALK: walk_cnt SHALL increment each cycle; if walk_cnt = MAX_WALK-1 on a non-leaf node, the block SHALL set out_class=4'hF and out_err=1 and move to DONE.
REQ-015 DONE: out_valid=1 and in_ready=0; out_class/out_err SHALL hold stable until out_ready=1, then the FSM SHALL return to LOAD with out_valid deasserted the next cycle.
REQ-016 Latency: if the last beat is accepted in cycle T and the path has k internal nodes, out_valid SHALL first be high in cycle T+k+2.
REQ-017 Threshold compare SHALL be unsigned 8-bit and inclusive (equality takes left).
REQ-018 Child indices >= N_NODES SHALL be treated as leaf class 4'hF with out_err=1.
REQ-019 in_valid while in_ready=0 SHALL be ignored; no beat is lost or double-counted.

Reset
REQ-020 On rst=1 at a clock edge:
- FSM=LOAD; beat_cnt, walk_cnt and node = 0.
- out_valid=0, out_class=0, out_err=0, in_ready=1 in the following cycle.
- The feature register file is not reset.
REQ-021 Reset mid-LOAD or mid-WALK SHALL discard the partial sample; the next accepted beat is feature 0.

Structure
REQ-022 Package dtree_pkg SHALL hold:
- constants N_FEAT=16, FEAT_W=8, CLASS_W=4, ERR_CLASS=4'hF;
- the node_t struct (is_leaf, fidx[3:0], thr[7:0], left, right, class[3:0]);
- the state enum;
- the NODE_TABLE constant array.
REQ-023 One sub-module dtree_node_eval SHALL be used: combinational, taking a node entry and the feature file, returning next-node, leaf flag and class.

Verification
Bench table: node0 {f7 <= 0x0F ? n1 : n2}; n1 leaf class 3; n2 {f15 <= 0x7F ? n3 : n4}; n3 leaf 5; n4 leaf 9.
REQ-024 16 beats of 0x00, out_ready=1 -> out_class=3, out_err=0, out_valid first at T+3.
REQ-025 f7=0x0F, others 0xFF -> class 3 (inclusive boundary). f7=0x10, f15=0x7F -> class 5 at T+4. f15=0x80 -> class 9.
REQ-026 out_ready held low 6 cycles in DONE -> out_valid, out_class stable; in_ready=0; in_valid beats ignored; after the handshake, the next sample is loaded from feature 0.
REQ-027 rst pulsed in the cycle after the 8th beat, then 16 fresh beats -> result reflects only the fresh sample; out_valid=0 during reset.
REQ-028 Table patched so node0 loops to itself -> out_err=1, out_class=4'hF, out_valid at T+MAX_WALK+1.
